sii_l2t_req_sched: RTL



---
 rtl/sii_l2t_pkg.sv | 18 +
 rtl/sii_rr_arb.sv | 43 ++++
 rtl/sii_l2t_req_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sii_l2t_pkg.sv
// sii_l2t_pkg: shared types and widths for the SII-to-L2 tag request scheduler.
package sii_l2t_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

  localparam int WORD_W = 32;
  localparam int BANK_W = 3;
  localparam int LEN_W  = 5;

  // Credit counters must hold 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sii_rr_arb.sv
// sii_rr_arb: round-robin arbiter; the pointer moves past the winner only
// when the grant is accepted (adv high).
module sii_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  // Scan from the pointer; the lowest offset with a request wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    ptr_nxt = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        ptr_nxt  = PW'((idx + 1) % NUM_REQ);
      end
    end
  end

  // Priority pointer; requester 0 is first after reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/sii_l2t_req_sched.sv
// sii_l2t_req_sched: streams requester packets onto per-bank L2 tag request
// buses under per-bank input-queue credit. Defining SII_L2T_SCHED_PERF_EN adds
// per-bank credit-stall counters on port stall_cnt.
module sii_l2t_req_sched
  import sii_l2t_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_BANK = 8,
  parameter int IQ_DEPTH = 4
) (
  input  logic                       iol2clk,
  input  logic                       rst_l,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*BANK_W-1:0]  req_bank,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*WORD_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_BANK*WORD_W-1:0] sii_l2t_req,
  output logic [NUM_BANK-1:0]        sii_l2t_req_vld,
  input  logic [NUM_BANK-1:0]        l2t_sii_iq_dequeue,
  output logic                       busy,
  output logic                       credit_err
`ifdef SII_L2T_SCHED_PERF_EN
  ,
  output logic [NUM_BANK*16-1:0]     stall_cnt
`endif
);

  localparam int CW = credit_w(IQ_DEPTH);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(IQ_DEPTH);

  sched_state_e        state, state_nxt;
  logic [CW-1:0]       credit [NUM_BANK];
  logic [OW-1:0]       owner;
  logic [BANK_W-1:0]   cur_bank;
  logic [LEN_W-1:0]    remaining;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [OW-1:0]       win_idx;
  logic [BANK_W-1:0]   win_bank;
  logic [LEN_W-1:0]    win_len;
  logic [NUM_BANK-1:0] cred_dec;

  logic                grant_p0;
  logic                vld_p0;
  logic [OW-1:0]       idx_p0;
  logic [BANK_W-1:0]   bank_p0;

  logic                vld_p1;
  logic                first_p1;
  logic [BANK_W-1:0]   bank_p1;
  logic [WORD_W-1:0]   word_p1;

  // A requester may compete only if its target bank has registered credit.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_vld[i] && (credit[req_bank[i*BANK_W +: BANK_W]] != '0);
  end

  sii_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (iol2clk),
    .rst_l (rst_l),
    .req   (elig),
    .adv   (grant_p0),
    .gnt   (arb_gnt)
  );

  // Convert the one-hot grant into the winner's index, bank and length.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) win_idx = OW'(i);
    win_bank = req_bank[int'(win_idx)*BANK_W +: BANK_W];
    win_len  = req_len[int'(win_idx)*LEN_W +: LEN_W];
  end

  // ---- stage p0: FSM decides which word is consumed this cycle ----
  always_comb begin
    state_nxt = state;
    grant_p0  = 1'b0;
    vld_p0    = 1'b0;
    idx_p0    = owner;
    bank_p0   = cur_bank;
    case (state)
      IDLE: begin
        if (|elig) begin
          grant_p0 = 1'b1;
          vld_p0   = 1'b1;
          idx_p0   = win_idx;
          bank_p0  = win_bank;
          if (win_len != '0) state_nxt = XFER;
        end
      end
      XFER: begin
        vld_p0 = 1'b1;
        if (remaining == LEN_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ack is combinational; held low while reset is asserted.
  always_comb begin
    req_ack = '0;
    if (vld_p0 && rst_l) req_ack[idx_p0] = 1'b1;
  end

  // FSM state, packet owner/bank and remaining word count.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      owner     <= '0;
      cur_bank  <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (grant_p0) begin
        owner     <= win_idx;
        cur_bank  <= win_bank;
        remaining <= win_len;
      end else if (state == XFER) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // Which bank loses a credit this cycle.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++)
      cred_dec[b] = grant_p0 && (win_bank == BANK_W'(b));
  end

  // Per-bank credits; a dequeue at full credit is an overflow and holds.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int b = 0; b < NUM_BANK; b++) credit[b] <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (cred_dec[b] && !l2t_sii_iq_dequeue[b]) begin
          credit[b] <= credit[b] - CW'(1);
        end else if (!cred_dec[b] && l2t_sii_iq_dequeue[b]) begin
          if (credit[b] == CRED_MAX) credit_err <= 1'b1;
          else                       credit[b]  <= credit[b] + CW'(1);
        end
      end
    end
  end

  // ---- stage p1: registered bus control ----
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      bank_p1  <= '0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= grant_p0;
      bank_p1  <= bank_p0;
    end
  end

  // Data word register; only visible when vld_p1 is set.
  always_ff @(posedge iol2clk) begin
    word_p1 <= req_data[int'(idx_p0)*WORD_W +: WORD_W];
  end

  // Steer the registered word onto its bank; every other bus reads zero.
  always_comb begin
    sii_l2t_req     = '0;
    sii_l2t_req_vld = '0;
    if (vld_p1) begin
      sii_l2t_req[int'(bank_p1)*WORD_W +: WORD_W] = word_p1;
      sii_l2t_req_vld[bank_p1]                    = first_p1;
    end
  end

  assign busy = (state == XFER);

`ifdef SII_L2T_SCHED_PERF_EN
  logic [NUM_BANK-1:0] stall_hit;
  logic [15:0]         stall_q [NUM_BANK];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A bank stalls when the idle scheduler sees a request for it with no credit.
  always_comb begin
    stall_hit = '0;
    if (state == IDLE)
      for (int i = 0; i < NUM_REQ; i++)
        if (req_vld[i] && (credit[req_bank[i*BANK_W +: BANK_W]] == '0))
          stall_hit[req_bank[i*BANK_W +: BANK_W]] = 1'b1;
  end

  // Saturating stall counters.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int b = 0; b < NUM_BANK; b++) stall_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++)
        if (stall_hit[b]) stall_q[b] <= sat_inc16(stall_q[b]);
    end
  end

  // Flatten counters onto the output port.
  always_comb begin
    stall_cnt = '0;
    for (int b = 0; b < NUM_BANK; b++) stall_cnt[b*16 +: 16] = stall_q[b];
  end
`endif

endmodule
